// File: rtl/run_length_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : run_det_pkg
//  Description : Shared types and constants for the run-length detector.
//                run_state_t : detector FSM state encoding (2'b00 is illegal)
//                THR_MIN     : smallest effective threshold (thr=0 maps here)
//  Revision    : 1.0 - initial release
// ============================================================================
package run_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b01,
        RUN  = 2'b10,
        HIT  = 2'b11
    } run_state_t;

    localparam int THR_MIN = 1;

endpackage
`default_nettype wire

// File: rtl/run_length_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_length_detector_if
//  Description : Sample/control/status bundle of the run-length detector.
//                master : stimulus side (drives x_vld, x, pol, thr, rearm)
//                slave  : detector side (drives z, hit, run_cnt)
//                Optional macro RUN_DET_STICKY_EN adds sticky / sticky_clr.
//  Revision    : 1.0 - initial release
// ============================================================================
interface run_length_detector_if #(
    parameter int CNT_W = 4
);
    logic             x_vld;
    logic             x;
    logic             pol;
    logic [CNT_W-1:0] thr;
    logic             rearm;
    logic             z;
    logic             hit;
    logic [CNT_W-1:0] run_cnt;
`ifdef RUN_DET_STICKY_EN
    logic             sticky;
    logic             sticky_clr;

    modport master (output x_vld, x, pol, thr, rearm, sticky_clr,
                    input  z, hit, run_cnt, sticky);
    modport slave  (input  x_vld, x, pol, thr, rearm, sticky_clr,
                    output z, hit, run_cnt, sticky);
`else
    modport master (output x_vld, x, pol, thr, rearm,
                    input  z, hit, run_cnt);
    modport slave  (input  x_vld, x, pol, thr, rearm,
                    output z, hit, run_cnt);
`endif
endinterface
`default_nettype wire

// File: rtl/run_length_detector_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Saturating up-counter holding the current run length.
//                clk/rst : clock, synchronous active-high reset
//                clr     : force to 0            (highest priority)
//                load1   : force to 1            (run restart after rearm)
//                inc     : +1, holds at all-ones (never wraps)
//                q       : count value
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    input  wire logic             clr,
    input  wire logic             load1,
    output logic      [CNT_W-1:0] q
);
    localparam logic [CNT_W-1:0] c_MAX = '1;

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_q <= '0;
        end else if (load1) begin
            r_q <= CNT_W'(1);
        end else if (inc && (r_q != c_MAX)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/run_length_detector.sv
`default_nettype none
// ============================================================================
//  Module      : run_length_detector
//  Description : Detects THR consecutive valid samples equal to a polarity bit.
//                Registered level z (state==HIT), one-cycle hit pulse on each
//                entry into HIT, saturating run counter, optional rearm mode.
//  Ports       : clk, rst (sync, active-high)
//                bus.x_vld/x/pol/thr/rearm  in
//                bus.z/hit/run_cnt          out
//                bus.sticky_clr in, bus.sticky out  (RUN_DET_STICKY_EN only)
//  Macro       : RUN_DET_STICKY_EN - latched hit flag with clear input
//  Note        : CNT_W must match the CNT_W of the connected interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int THR_DEF = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    run_length_detector_if.slave bus
);
    localparam logic [CNT_W-1:0] c_MAX = '1;

    run_state_t       r_state;
    run_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_thr;
    logic [CNT_W-1:0] w_thr_eff;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_n;
    logic             w_inc;
    logic             w_clr;
    logic             w_load1;
    logic             w_hit_nxt;
    logic             r_z;
    logic             r_hit;

    assign w_thr_eff = (r_thr == '0) ? CNT_W'(THR_MIN) : r_thr;
    // Run length the counter would hold after one more match.
    assign w_n       = (w_cnt == c_MAX) ? w_cnt : w_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_clr       = 1'b0;
        w_load1     = 1'b0;
        w_hit_nxt   = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                if (bus.x_vld) begin
                    if (bus.x != bus.pol) begin
                        w_clr       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_inc = 1'b1;
                        if (w_n >= w_thr_eff) begin
                            w_state_nxt = HIT;
                            w_hit_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end
                end
            end
            HIT: begin
                if (bus.x_vld) begin
                    if (bus.x != bus.pol) begin
                        w_clr       = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (bus.rearm) begin
                        // Non-overlapping mode: the matching sample starts a fresh run.
                        w_load1 = 1'b1;
                        if (w_thr_eff == CNT_W'(THR_MIN)) begin
                            w_state_nxt = HIT;
                            w_hit_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = RUN;
                        end
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                w_clr       = 1'b1;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_z     <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_z     <= (w_state_nxt == HIT);
            r_hit   <= w_hit_nxt;
        end
    end

    // Threshold only follows the input while idle, so a run is judged
    // against the value in force when it started.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr <= CNT_W'(THR_DEF);
        end else if (r_state == IDLE) begin
            r_thr <= bus.thr;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_inc),
        .clr   (w_clr),
        .load1 (w_load1),
        .q     (w_cnt)
    );

    assign bus.z       = r_z;
    assign bus.hit     = r_hit;
    assign bus.run_cnt = w_cnt;

`ifdef RUN_DET_STICKY_EN
    logic r_sticky;

    // Set has priority over clear so a hit coinciding with a clear is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_hit_nxt) begin
            r_sticky <= 1'b1;
        end else if (bus.sticky_clr) begin
            r_sticky <= 1'b0;
        end
    end

    assign bus.sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_length_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_length_detector
//  Description : Directed self-checking bench for run_length_detector.
//                Compares {z, hit, run_cnt} after each clock against
//                hand-computed vectors; sticky checks under RUN_DET_STICKY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_run_length_detector;

    localparam int CNT_W = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    run_length_detector_if #(.CNT_W(CNT_W)) bus ();

    run_length_detector #(
        .CNT_W   (CNT_W),
        .THR_DEF (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic xv);
        bus.x_vld = vld;
        bus.x     = xv;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.pol   = 1'b1;
        bus.thr   = 4'd2;
        bus.rearm = 1'b0;
        drive(1'b0, 1'b0);
`ifdef RUN_DET_STICKY_EN
        bus.sticky_clr = 1'b0;
`endif
        tick();
        tick();
        checks++;
        if ({bus.z, bus.hit, bus.run_cnt} !== 6'b00_0000) begin
            errors++;
            $display("FAIL reset: got z/hit/cnt=%b required 000000", {bus.z, bus.hit, bus.run_cnt});
        end
`ifdef RUN_DET_STICKY_EN
        checks++;
        if (bus.sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: got %b required 0", bus.sticky);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    // thr=2, rearm=0: 1,1,1,0
    task automatic test_basic();
        logic       ez[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       eh[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] ec[4]   = '{4'd1, 4'd2, 4'd3, 4'd0};
        logic       xs[4]   = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, xs[i]);
            tick();
            checks++;
            if ({bus.z, bus.hit, bus.run_cnt} !== {ez[i], eh[i], ec[i]}) begin
                errors++;
                $display("FAIL basic[%0d]: got z/hit/cnt=%b required %b", i,
                         {bus.z, bus.hit, bus.run_cnt}, {ez[i], eh[i], ec[i]});
            end
        end
        drive(1'b0, 1'b0);
        tick();
    endtask

    // thr=3, rearm=1: six matches -> hit after 3rd and 6th
    task automatic test_rearm();
        logic       ez[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] ec[6] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};
        bus.thr   = 4'd3;
        bus.rearm = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1);
            tick();
            checks++;
            if ({bus.z, bus.hit, bus.run_cnt} !== {ez[i], ez[i], ec[i]}) begin
                errors++;
                $display("FAIL rearm[%0d]: got z/hit/cnt=%b required %b", i,
                         {bus.z, bus.hit, bus.run_cnt}, {ez[i], ez[i], ec[i]});
            end
        end
        drive(1'b1, 1'b0);
        tick();
        checks++;
        if ({bus.z, bus.hit, bus.run_cnt} !== 6'b00_0000) begin
            errors++;
            $display("FAIL rearm_break: got z/hit/cnt=%b required 000000", {bus.z, bus.hit, bus.run_cnt});
        end
        drive(1'b0, 1'b0);
        tick();
    endtask

    // thr=1, rearm=1: every match re-enters HIT and re-fires hit
    task automatic test_back_to_back();
        bus.thr   = 4'd1;
        bus.rearm = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            tick();
            checks++;
            if ({bus.z, bus.hit, bus.run_cnt} !== 6'b11_0001) begin
                errors++;
                $display("FAIL b2b[%0d]: got z/hit/cnt=%b required 110001", i, {bus.z, bus.hit, bus.run_cnt});
            end
        end
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        bus.rearm = 1'b0;
        tick();
    endtask

    // pol=0, thr=2: a gap in x_vld holds the run
    task automatic test_gap();
        bus.pol = 1'b0;
        bus.thr = 4'd2;
        tick();
        drive(1'b1, 1'b0);
        tick();
        checks++;
        if ({bus.z, bus.hit, bus.run_cnt} !== 6'b00_0001) begin
            errors++;
            $display("FAIL gap_first: got z/hit/cnt=%b required 000001", {bus.z, bus.hit, bus.run_cnt});
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1);
            tick();
            checks++;
            if ({bus.z, bus.hit, bus.run_cnt} !== 6'b00_0001) begin
                errors++;
                $display("FAIL gap_hold[%0d]: got z/hit/cnt=%b required 000001", i, {bus.z, bus.hit, bus.run_cnt});
            end
        end
        drive(1'b1, 1'b0);
        tick();
        checks++;
        if ({bus.z, bus.hit, bus.run_cnt} !== 6'b11_0010) begin
            errors++;
            $display("FAIL gap_hit: got z/hit/cnt=%b required 110010", {bus.z, bus.hit, bus.run_cnt});
        end
        drive(1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0);
        bus.pol = 1'b1;
        tick();
    endtask

    // thr=0 acts as 1; counter saturates at 15 with a single hit pulse
    task automatic test_saturate();
        logic [3:0] ec;
        logic       eh;
        bus.thr = 4'd0;
        tick();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 1'b1);
            tick();
            ec = (i > 15) ? 4'd15 : 4'(i);
            eh = (i == 1);
            checks++;
            if ({bus.z, bus.hit, bus.run_cnt} !== {1'b1, eh, ec}) begin
                errors++;
                $display("FAIL sat[%0d]: got z/hit/cnt=%b required %b", i,
                         {bus.z, bus.hit, bus.run_cnt}, {1'b1, eh, ec});
            end
        end
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        tick();
    endtask

    // thr changed mid-run is ignored until the run breaks
    task automatic test_thr_freeze();
        bus.thr = 4'd2;
        tick();
        drive(1'b1, 1'b1);
        tick();
        bus.thr = 4'd5;
        drive(1'b1, 1'b1);
        tick();
        checks++;
        if ({bus.z, bus.hit, bus.run_cnt} !== 6'b11_0010) begin
            errors++;
            $display("FAIL freeze_old_thr: got z/hit/cnt=%b required 110010", {bus.z, bus.hit, bus.run_cnt});
        end
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1);
            tick();
            checks++;
            if ({bus.z, bus.hit, bus.run_cnt} !== {(i == 5), (i == 5), 4'(i)}) begin
                errors++;
                $display("FAIL freeze_new_thr[%0d]: got z/hit/cnt=%b required %b", i,
                         {bus.z, bus.hit, bus.run_cnt}, {(i == 5), (i == 5), 4'(i)});
            end
        end
        drive(1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0);
        bus.thr = 4'd2;
        tick();
    endtask

    // Reset while in HIT discards the run; sticky set wins over clear
    task automatic test_reset_in_hit();
        drive(1'b1, 1'b1);
        tick();
        tick();
        checks++;
        if ({bus.z, bus.hit} !== 2'b11) begin
            errors++;
            $display("FAIL pre_rst_hit: got z/hit=%b required 11", {bus.z, bus.hit});
        end
`ifdef RUN_DET_STICKY_EN
        checks++;
        if (bus.sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: got %b required 1", bus.sticky);
        end
`endif
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.z, bus.hit, bus.run_cnt} !== 6'b00_0000) begin
            errors++;
            $display("FAIL rst_in_hit: got z/hit/cnt=%b required 000000", {bus.z, bus.hit, bus.run_cnt});
        end
`ifdef RUN_DET_STICKY_EN
        checks++;
        if (bus.sticky !== 1'b0) begin
            errors++;
            $display("FAIL rst_sticky: got %b required 0", bus.sticky);
        end
`endif
        rst = 1'b0;
        drive(1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1);
        tick();
`ifdef RUN_DET_STICKY_EN
        bus.sticky_clr = 1'b1;
`endif
        tick();
        checks++;
        if ({bus.z, bus.hit, bus.run_cnt} !== 6'b11_0010) begin
            errors++;
            $display("FAIL post_rst_hit: got z/hit/cnt=%b required 110010", {bus.z, bus.hit, bus.run_cnt});
        end
`ifdef RUN_DET_STICKY_EN
        checks++;
        if (bus.sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins: got %b required 1", bus.sticky);
        end
        drive(1'b0, 1'b0);
        tick();
        checks++;
        if (bus.sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: got %b required 0", bus.sticky);
        end
        bus.sticky_clr = 1'b0;
`endif
        drive(1'b0, 1'b0);
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_rearm();
        test_back_to_back();
        test_gap();
        test_saturate();
        test_thr_freeze();
        test_reset_in_hit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
